// File: rtl/pe_pkg.sv
// Shared definitions for the parallel PE feeder slice.
//
// Contents:
//   CHUNK_W / LANES / LANE_W / RES_W  - datapath geometry of one PE chunk
//   CTL_FIRST / CTL_LAST              - bit positions inside the 2-bit ctl tag
//   feed_state_t                      - sequencing FSM state encoding
//   make_ctl()                        - packs first/last flags into a ctl tag
package pe_pkg;

   localparam int CHUNK_W = 512;
   localparam int LANES   = 32;
   localparam int LANE_W  = 16;
   localparam int RES_W   = 32;

   localparam int CTL_FIRST = 0;
   localparam int CTL_LAST  = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } feed_state_t;

   // Keeps the tag bit placement in one spot so producer and any consumer agree.
   function automatic logic [1:0] make_ctl(input logic first, input logic last);
      logic [1:0] ctl;
      ctl            = '0;
      ctl[CTL_FIRST] = first;
      ctl[CTL_LAST]  = last;
      return ctl;
   endfunction

endpackage

// File: rtl/pe_feed_addr_gen.sv
// Read address generator for the PE feeder.
//
// Walks the (o, k) iteration space of a dot-product layer at one chunk per
// cycle while 'run' is high. The weight address o*vec_len+k is formed from a
// running base register that advances by vec_len on every output wrap, so no
// multiplier is needed.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          restart the walk at o=0, k=0, base=0
//   run            issue one read this cycle and advance the counters
//   vec_len        latched chunks per output (nonzero while running)
//   out_num        latched number of outputs (nonzero while running)
//   rd             read enable for both SRAMs
//   nram_addr      neuron chunk index k (0 when not reading)
//   wram_addr      weight chunk index base+k (0 when not reading)
//   ctl            first/last tag for the chunk being read
//   final_rd       this read is the last chunk of the last output
module pe_feed_addr_gen
   import pe_pkg::*;
#(
   parameter int NAW = 10,
   parameter int WAW = 16,
   parameter int OW  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           run,
   input  logic [NAW-1:0] vec_len,
   input  logic [OW-1:0]  out_num,
   output logic           rd,
   output logic [NAW-1:0] nram_addr,
   output logic [WAW-1:0] wram_addr,
   output logic [1:0]     ctl,
   output logic           final_rd
);

   logic [NAW-1:0] k_q;
   logic [OW-1:0]  o_q;
   logic [WAW-1:0] base_q;
   logic           first;
   logic           last;

   assign first = (k_q == '0);
   assign last  = (k_q == vec_len - NAW'(1));

   // k/o counters and the weight base; at the end of an output k wraps to 0
   // in the same cycle o and base advance, so reads continue without a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q    <= '0;
         o_q    <= '0;
         base_q <= '0;
      end else if (clear) begin
         k_q    <= '0;
         o_q    <= '0;
         base_q <= '0;
      end else if (run) begin
         if (last) begin
            k_q    <= '0;
            o_q    <= o_q + OW'(1);
            base_q <= base_q + WAW'(vec_len);
         end else begin
            k_q <= k_q + NAW'(1);
         end
      end
   end

   // Addresses and tags are forced to zero outside of reads so the SRAM and
   // PE side see quiet buses while idle.
   assign rd        = run;
   assign nram_addr = run ? k_q : '0;
   assign wram_addr = run ? (base_q + WAW'(k_q)) : '0;
   assign ctl       = run ? make_ctl(first, last) : 2'b00;
   assign final_rd  = run && last && (o_q == out_num - OW'(1));

endmodule

// File: rtl/pe_feeder.sv
// Initiator side of the parallel PE interface.
//
// Sequences one dot-product layer: streams neuron/weight chunks from two
// single-port SRAMs (1-cycle read latency) into a parallel_pe, tags each
// chunk with first/last, and writes every PE result into a result buffer.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle request; latches vec_len/out_num
//   vec_len, out_num        chunks per output, number of outputs
//   busy, done              job in progress, one-cycle completion pulse
//   nram_rd/addr/data       neuron SRAM read port
//   wram_rd/addr/data       weight SRAM read port
//   pe_neuron/weight/ctl/vld  chunk stream into the PE
//   pe_result, pe_vld_o     PE result return
//   res_we/addr/data        result buffer write port
module pe_feeder
   import pe_pkg::*;
#(
   parameter int NAW = 10,
   parameter int WAW = 16,
   parameter int OW  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [NAW-1:0]     vec_len,
   input  logic [OW-1:0]      out_num,
   output logic               busy,
   output logic               done,
   output logic               nram_rd,
   output logic [NAW-1:0]     nram_addr,
   input  logic [CHUNK_W-1:0] nram_data,
   output logic               wram_rd,
   output logic [WAW-1:0]     wram_addr,
   input  logic [CHUNK_W-1:0] wram_data,
   output logic [CHUNK_W-1:0] pe_neuron,
   output logic [CHUNK_W-1:0] pe_weight,
   output logic [1:0]         pe_ctl,
   output logic               pe_vld,
   input  logic [RES_W-1:0]   pe_result,
   input  logic               pe_vld_o,
   output logic               res_we,
   output logic [OW-1:0]      res_addr,
   output logic [RES_W-1:0]   res_data
);

   feed_state_t    state_q;
   feed_state_t    state_d;
   logic [NAW-1:0] vec_len_q;
   logic [OW-1:0]  out_num_q;
   logic [OW-1:0]  res_cnt_q;
   logic [OW-1:0]  res_cnt_next;
   logic           sizes_ok;
   logic           accept;
   logic           run;
   logic           gen_rd;
   logic [1:0]     gen_ctl;
   logic           final_rd;
   logic           pe_vld_q;
   logic [1:0]     pe_ctl_q;

   assign sizes_ok = (vec_len != '0) && (out_num != '0);
   assign accept   = (state_q == ST_IDLE) && start && sizes_ok;
   assign run      = (state_q == ST_RUN);

   pe_feed_addr_gen #(
      .NAW (NAW),
      .WAW (WAW),
      .OW  (OW)
   ) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (accept),
      .run       (run),
      .vec_len   (vec_len_q),
      .out_num   (out_num_q),
      .rd        (gen_rd),
      .nram_addr (nram_addr),
      .wram_addr (wram_addr),
      .ctl       (gen_ctl),
      .final_rd  (final_rd)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Job sizes are captured only on an accepted start, so a start seen
   // while busy cannot disturb the running layer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_len_q <= '0;
         out_num_q <= '0;
      end else if (accept) begin
         vec_len_q <= vec_len;
         out_num_q <= out_num;
      end
   end

   // The SRAM data arrives one cycle after the read, so the valid and tag
   // travel through one register to line up with it at the PE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_vld_q <= 1'b0;
         pe_ctl_q <= 2'b00;
      end else begin
         pe_vld_q <= gen_rd;
         pe_ctl_q <= gen_ctl;
      end
   end

   // Result counter; results can land while reads are still being issued
   // when vec_len is small, so it counts in every non-idle state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_cnt_q <= '0;
      end else if (accept) begin
         res_cnt_q <= '0;
      end else if (res_we) begin
         res_cnt_q <= res_cnt_next;
      end
   end

   assign res_cnt_next = res_cnt_q + OW'(res_we);

   // Next-state logic. A zero-sized request skips straight to FIN so the
   // caller still gets its done pulse. DRAIN compares against the count
   // including this cycle's write, which saves one cycle of latency.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = sizes_ok ? ST_RUN : ST_FIN;
            end
         end
         ST_RUN: begin
            if (final_rd) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (res_cnt_next == out_num_q) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_FIN);
   assign nram_rd   = gen_rd;
   assign wram_rd   = gen_rd;
   assign pe_neuron = nram_data;
   assign pe_weight = wram_data;
   assign pe_vld    = pe_vld_q;
   assign pe_ctl    = pe_ctl_q;

   // A stray PE result while idle is not written anywhere.
   assign res_we   = pe_vld_o && (state_q != ST_IDLE);
   assign res_addr = res_we ? res_cnt_q : '0;
   assign res_data = res_we ? pe_result : '0;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: SRAM and PE behavioural stand-ins,
// a table of directed jobs, multi-cycle corner sequences and random jobs
// checked against an arithmetic reference model.
module tb_pe_feeder;

   localparam int NAW = 10;
   localparam int WAW = 16;
   localparam int OW  = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [NAW-1:0] vec_len;
   logic [OW-1:0]  out_num;
   logic           busy;
   logic           done;
   logic           nram_rd;
   logic [NAW-1:0] nram_addr;
   logic [511:0]   nram_data;
   logic           wram_rd;
   logic [WAW-1:0] wram_addr;
   logic [511:0]   wram_data;
   logic [511:0]   pe_neuron;
   logic [511:0]   pe_weight;
   logic [1:0]     pe_ctl;
   logic           pe_vld;
   logic [31:0]    pe_result;
   logic           pe_vld_o;
   logic           res_we;
   logic [OW-1:0]  res_addr;
   logic [31:0]    res_data;

   pe_feeder #(.NAW(NAW), .WAW(WAW), .OW(OW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .vec_len   (vec_len),
      .out_num   (out_num),
      .busy      (busy),
      .done      (done),
      .nram_rd   (nram_rd),
      .nram_addr (nram_addr),
      .nram_data (nram_data),
      .wram_rd   (wram_rd),
      .wram_addr (wram_addr),
      .wram_data (wram_data),
      .pe_neuron (pe_neuron),
      .pe_weight (pe_weight),
      .pe_ctl    (pe_ctl),
      .pe_vld    (pe_vld),
      .pe_result (pe_result),
      .pe_vld_o  (pe_vld_o),
      .res_we    (res_we),
      .res_addr  (res_addr),
      .res_data  (res_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [511:0] nmem [64];
   logic [511:0] wmem [256];

   // 32-lane unsigned dot product with 32-bit wraparound accumulation.
   function automatic logic [31:0] dot(input logic [511:0] a, input logic [511:0] b);
      logic [31:0] s;
      s = '0;
      for (int l = 0; l < 32; l++) begin
         s = s + 32'(a[l*16 +: 16]) * 32'(b[l*16 +: 16]);
      end
      return s;
   endfunction

   // SRAM stand-ins with one cycle of read latency.
   always @(posedge clk) begin
      if (nram_rd) nram_data <= nmem[nram_addr[5:0]];
      if (wram_rd) wram_data <= wmem[wram_addr[7:0]];
   end

   // PE stand-in: first chunk restarts the sum, last chunk returns it a cycle later.
   logic [31:0] psum = '0;
   always @(posedge clk) begin
      logic [31:0] s;
      pe_vld_o <= 1'b0;
      if (pe_vld) begin
         s = (pe_ctl[0] ? 32'd0 : psum) + dot(pe_neuron, pe_weight);
         psum <= s;
         if (pe_ctl[1]) begin
            pe_vld_o  <= 1'b1;
            pe_result <= s;
         end
      end
   end

   // Event monitor, sampled mid-cycle.
   int rd_n_q[$];
   int rd_w_q[$];
   int rd_cyc_q[$];
   int ctl_q[$];
   int wr_addr_q[$];
   int wr_data_q[$];
   int wr_cyc_q[$];
   int done_cyc_q[$];
   int rd_pair_bad;
   always @(negedge clk) begin
      if (nram_rd !== wram_rd) rd_pair_bad++;
      if (nram_rd) begin
         rd_n_q.push_back(int'(nram_addr));
         rd_w_q.push_back(int'(wram_addr));
         rd_cyc_q.push_back(cyc);
      end
      if (pe_vld) ctl_q.push_back(int'(pe_ctl));
      if (res_we) begin
         wr_addr_q.push_back(int'(res_addr));
         wr_data_q.push_back(int'(res_data));
         wr_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic clear_monitor();
      rd_n_q.delete();
      rd_w_q.delete();
      rd_cyc_q.delete();
      ctl_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      done_cyc_q.delete();
      rd_pair_bad = 0;
   endtask

   // pat 0: neuron 1 / weight 2; pat 1: neuron 1 / weight o+1; pat 2: random.
   task automatic fill_mem(input int pat, input int vl);
      for (int a = 0; a < 256; a++) begin
         for (int l = 0; l < 32; l++) begin
            if (a < 64) nmem[a][l*16 +: 16] = (pat == 2) ? 16'($urandom_range(0, 255)) : 16'd1;
            case (pat)
               0:       wmem[a][l*16 +: 16] = 16'd2;
               1:       wmem[a][l*16 +: 16] = 16'(a / ((vl == 0) ? 1 : vl) + 1);
               default: wmem[a][l*16 +: 16] = 16'($urandom_range(0, 255));
            endcase
         end
      end
   endtask

   int last_cycles;
   int last_writes;
   int last_first;
   int last_last;

   // Runs one job and checks everything against the reference model.
   task automatic applyStimulus(input int vl, input int on, input int inject, input string tag);
      int t0;
      int exp_reads;
      int exp_done;
      int w;
      logic [31:0] er;
      clear_monitor();
      @(posedge clk); #1;
      vec_len = NAW'(vl);
      out_num = OW'(on);
      start   = 1'b1;
      t0      = cyc;
      @(posedge clk); #1;
      start   = 1'b0;
      vec_len = NAW'(7);
      out_num = OW'(9);
      exp_reads = (vl != 0 && on != 0) ? vl * on : 0;
      exp_done  = (exp_reads != 0) ? exp_reads + 3 : 1;
      if (exp_reads != 0) checkOutput({tag, "_busy_after_start"}, busy, 1);
      w = 0;
      while (done_cyc_q.size() == 0 && w < 400) begin
         if (inject != 0 && w == 2) begin
            vec_len = NAW'(5);
            out_num = OW'(7);
            start   = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         w++;
      end
      start = 1'b0;
      if (done_cyc_q.size() == 0) begin
         checkOutput({tag, "_done_timeout"}, 0, 1);
      end else begin
         checkOutput({tag, "_busy_after_done"}, busy, 0);
         checkOutput({tag, "_done_width"}, done, 0);
      end
      repeat (4) @(posedge clk);
      #1;
      checkOutput({tag, "_done_count"}, done_cyc_q.size(), 1);
      last_cycles = (done_cyc_q.size() != 0) ? done_cyc_q[0] - t0 : -1;
      checkOutput({tag, "_start_to_done"}, last_cycles, exp_done);
      checkOutput({tag, "_rd_pairing"}, rd_pair_bad, 0);
      checkOutput({tag, "_read_count"}, rd_n_q.size(), exp_reads);
      checkOutput({tag, "_pe_vld_count"}, ctl_q.size(), exp_reads);
      for (int j = 0; j < exp_reads; j++) begin
         int o;
         int k;
         o = j / vl;
         k = j % vl;
         if (j < rd_n_q.size()) begin
            checkOutput($sformatf("%s_naddr%0d", tag, j), rd_n_q[j], k);
            checkOutput($sformatf("%s_waddr%0d", tag, j), rd_w_q[j], o * vl + k);
            checkOutput($sformatf("%s_rdcyc%0d", tag, j), rd_cyc_q[j], t0 + 1 + j);
         end
         if (j < ctl_q.size()) begin
            checkOutput($sformatf("%s_ctl%0d", tag, j), ctl_q[j],
                        ((k == vl - 1) ? 2 : 0) + ((k == 0) ? 1 : 0));
         end
      end
      last_writes = wr_addr_q.size();
      checkOutput({tag, "_write_count"}, last_writes, (exp_reads != 0) ? on : 0);
      for (int o = 0; o < ((exp_reads != 0) ? on : 0); o++) begin
         er = '0;
         for (int k = 0; k < vl; k++) er = er + dot(nmem[k], wmem[o * vl + k]);
         if (o < wr_addr_q.size()) begin
            checkOutput($sformatf("%s_res_addr%0d", tag, o), wr_addr_q[o], o);
            checkOutput($sformatf("%s_res_data%0d", tag, o), 32'(wr_data_q[o]), er);
            checkOutput($sformatf("%s_res_cyc%0d", tag, o), wr_cyc_q[o], t0 + 2 + (o + 1) * vl);
         end
      end
      last_first = (last_writes != 0) ? wr_data_q[0] : 0;
      last_last  = (last_writes != 0) ? wr_data_q[last_writes - 1] : 0;
   endtask

   task automatic check_quiet(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_nram_rd"}, nram_rd, 0);
      checkOutput({tag, "_wram_rd"}, wram_rd, 0);
      checkOutput({tag, "_nram_addr"}, nram_addr, 0);
      checkOutput({tag, "_wram_addr"}, wram_addr, 0);
      checkOutput({tag, "_pe_vld"}, pe_vld, 0);
      checkOutput({tag, "_pe_ctl"}, pe_ctl, 0);
      checkOutput({tag, "_res_we"}, res_we, 0);
      checkOutput({tag, "_res_addr"}, res_addr, 0);
   endtask

   typedef struct {
      int vl;
      int on;
      int pat;
      int inject;
      int exp_cycles;
      int exp_writes;
      int exp_first;
      int exp_last;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1, 1, 0, 0, 4, 1, 64, 64};
      vecs[1] = '{3, 2, 1, 0, 9, 2, 96, 192};
      vecs[2] = '{3, 2, 1, 1, 9, 2, 96, 192};
      vecs[3] = '{0, 3, 0, 0, 1, 0, 0, 0};
      vecs[4] = '{2, 0, 0, 0, 1, 0, 0, 0};
      vecs[5] = '{1, 4, 1, 0, 7, 4, 32, 128};
      vecs[6] = '{4, 1, 0, 0, 7, 1, 256, 256};

      rst_n   = 1'b0;
      start   = 1'b0;
      vec_len = '0;
      out_num = '0;
      #12;
      check_quiet("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         string tg;
         tg = $sformatf("v%0d", i);
         fill_mem(vecs[i].pat, vecs[i].vl);
         applyStimulus(vecs[i].vl, vecs[i].on, vecs[i].inject, tg);
         checkOutput({tg, "_tbl_cycles"}, last_cycles, vecs[i].exp_cycles);
         checkOutput({tg, "_tbl_writes"}, last_writes, vecs[i].exp_writes);
         if (vecs[i].exp_writes != 0) begin
            checkOutput({tg, "_tbl_first"}, last_first, vecs[i].exp_first);
            checkOutput({tg, "_tbl_last"}, last_last, vecs[i].exp_last);
         end
      end

      // Asynchronous reset in the middle of a RUN, then a clean restart.
      fill_mem(2, 4);
      clear_monitor();
      @(posedge clk); #1;
      vec_len = NAW'(4);
      out_num = OW'(3);
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_quiet("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("midrst_no_done", done_cyc_q.size(), 0);
      applyStimulus(4, 3, 0, "post_rst");

      // Random jobs against the reference model.
      for (int r = 0; r < 10; r++) begin
         int vl;
         int on;
         vl = (r == 9) ? 0 : $urandom_range(1, 6);
         on = $urandom_range(1, 6);
         fill_mem(2, vl);
         applyStimulus(vl, on, $urandom_range(0, 1), $sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
